// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle valid and
// framing_error strobes. Timing shares the CLOCKS_PER_BAUD convention of uart_tx.
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CW   = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam int HALF = CLOCKS_PER_BAUD / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLOCKS_PER_BAUD - 1);

    // Exposed by name so checkers can bind to the current state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic [7:0]    data_next;
    logic          valid_next, fe_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            sync1         <= rx;
            rx_s          <= sync1;
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_idx_next;
            shift         <= shift_next;
            data          <= data_next;
            valid         <= valid_next;
            framing_error <= fe_next;
        end
    end

    // The counter restarts at every sample point, so each state times from its own entry.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = data;
        valid_next   = 1'b0;
        fe_next      = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) state_next = STOP;
                    else                 bit_idx_next = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fe_next    = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of `uart_tx`, sharing its `CLOCKS_PER_BAUD` timing convention.
- Deserialises the asynchronous `rx` line into bytes.
- Emits each byte with a one-cycle `valid` strobe and flags malformed frames.
- Sits at the host-facing edge of the debug core, feeding received bytes to the command/bridge logic.

Parameters:
- `CLOCKS_PER_BAUD`, 868, clock cycles per bit period. Must be at least 4. Odd values are allowed; half-period = `CLOCKS_PER_BAUD`/2, truncated.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `rx` input 1: serial line. Asynchronous to `clk`; idles high.
- `data` output 8: last correctly framed byte received. Holds value between frames.
- `valid` output 1: one-cycle strobe; `data` is new this cycle.
- `framing_error` output 1: one-cycle strobe; stop bit was sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - FSM→IDLE, counters cleared.
  - `data`=8'h00, `valid`=0, `framing_error`=0, `busy`=0.
  - Both synchroniser flops set to 1.
  - Reset mid-frame abandons the frame; no strobes are produced for it.
- Synchroniser: `rx` passes through 2 flops; the FSM sees only `rx_s`, which lags `rx` by 2 cycles.
- Timing reference: T0 = the cycle in which IDLE first sees `rx_s`=0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On `rx_s`=0: →START, baud counter cleared.
  - Otherwise remain in IDLE.
- START: at T0+`CLOCKS_PER_BAUD`/2, sample `rx_s`.
  - 0: →DATA, counter cleared, bit index=0.
  - 1: glitch/false start; →IDLE with no strobe.
- DATA:
  - Bit i (i=0..7) is sampled at T0+`CLOCKS_PER_BAUD`/2+(i+1)·`CLOCKS_PER_BAUD`.
  - Bits are shifted in LSB-first.
  - After bit 7: →STOP.
- STOP: sample at T0+`CLOCKS_PER_BAUD`/2+9·`CLOCKS_PER_BAUD`.
  - 1: `data`←shift register and `valid`=1 in the next cycle only; →IDLE.
  - 0: `framing_error`=1 in the next cycle only; `data` unchanged; →WAIT_HIGH.
- WAIT_HIGH: remain until `rx_s`=1, then →IDLE. A held-low line (break) yields exactly one `framing_error` and no further strobes.
- Back-to-back frames:
  - IDLE is re-entered at mid-stop-bit, so a start edge arriving one half-bit later is caught.
  - Frames with exactly 1 stop bit are received with no loss.
- Strobe rules:
  - `valid` and `framing_error` are never high together.
  - Each frame produces at most one strobe.
- `busy`: high from T0+1 until IDLE is re-entered.
- Baud counter:
  - Wide enough to hold `CLOCKS_PER_BAUD`-1 ($clog2).
  - Wraps to 0 on every sample point; never free-runs past `CLOCKS_PER_BAUD`-1.
- No parity, no oversampling vote; a single sample per bit.

Test Plan (`CLOCKS_PER_BAUD`=10, bench drives `rx` through a model of `uart_tx`; T0 counted from first low `rx_s`):
1. Single byte: send 8'h69 → exactly one `valid` pulse, at T0+96 (sample at T0+95); `data`=8'h69; `framing_error` never high; `busy` low afterwards.
2. Back-to-back: send 8'h69 then 8'h42 with 1 stop bit and no idle gap → two `valid` pulses 100 cycles apart; `data`=8'h69, then 8'h42.
3. Glitch rejection: pulse `rx` low for 3 cycles in idle → no `valid` or `framing_error`; `busy` falls after ≤6 cycles. A subsequent 8'h42 frame is received correctly.
4. Framing error and break, with `data` already holding 8'h69:
   - Drive start, bits of 8'hA5, stop bit = 0, then hold `rx` low for 50 cycles → one `framing_error` pulse; no `valid`; `data` still 8'h69; `busy` stays high while `rx` is low.
   - Release `rx` high, then send 8'h3C → `valid` with `data`=8'h3C.
5. Reset mid-frame: assert `rst_n`=0 for 1 cycle during data bit 4 of 8'hFF → outputs return to reset values; no strobe for that frame. Remainder of the line-level frame may cause at most a glitch-rejected start; the next clean 8'h55 frame is received correctly.
6. Exhaustive loopback: all 256 byte values through `uart_tx`→`uart_rx` → every byte received in order, 256 `valid` pulses, 0 `framing_error`.
